// File: rtl/tetris_pkg.sv
// Shared constants, types and helpers for the playfield pipeline.
// ROWS/COLS     : visible playfield size (row 0 = top, row ROWS-1 = bottom)
// row_t         : one playfield row, bit c = column c occupied
// lc_state_t    : line_clear FSM states
// line_score()  : points awarded for n rows cleared in one operation
package tetris_pkg;

    localparam int unsigned ROWS     = 20;
    localparam int unsigned COLS     = 10;
    localparam int unsigned LC_IDX_W = $clog2(ROWS);
    // One extra bit so the pointer may step past row 0 without wrapping into a valid row.
    localparam int unsigned LC_PTR_W = $clog2(ROWS) + 1;
    localparam int unsigned LC_CNT_W = $clog2(ROWS + 1);
    localparam int unsigned SCORE_W  = 20;

    typedef logic [COLS-1:0] row_t;

    typedef enum logic [1:0] {LC_IDLE, LC_SCAN, LC_FILL, LC_DONE} lc_state_t;

    function automatic logic [SCORE_W-1:0] line_score(input logic [LC_CNT_W-1:0] n);
        logic [SCORE_W-1:0] pts;
        case (n)
            LC_CNT_W'(0): pts = 20'd0;
            LC_CNT_W'(1): pts = 20'd40;
            LC_CNT_W'(2): pts = 20'd100;
            LC_CNT_W'(3): pts = 20'd300;
            default:      pts = 20'd1200;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/line_clear_if.sv
// Handshake/data bundle between the piece-control FSM and the line_clear stage.
// start, grid_i          : request and playfield snapshot (driven by master)
// busy, done             : operation status (driven by slave)
// grid_o, lines_cleared  : compacted grid and rows removed (driven by slave)
// score                  : running score, present only when LINE_CLEAR_SCORE_EN is defined
interface line_clear_if;
    import tetris_pkg::*;

    logic                start;
    row_t                grid_i [ROWS];
    logic                busy;
    logic                done;
    row_t                grid_o [ROWS];
    logic [LC_CNT_W-1:0] lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W-1:0]  score;
`endif

    modport master (
`ifdef LINE_CLEAR_SCORE_EN
        input  score,
`endif
        output start,
        output grid_i,
        input  busy,
        input  done,
        input  grid_o,
        input  lines_cleared
    );

    modport slave (
`ifdef LINE_CLEAR_SCORE_EN
        output score,
`endif
        input  start,
        input  grid_i,
        output busy,
        output done,
        output grid_o,
        output lines_cleared
    );

endinterface

// File: rtl/line_clear_score_lut.sv
// Combinational points lookup for the number of rows cleared in one operation.
// n      : rows cleared
// points : score increment
module line_score_lut
    import tetris_pkg::*;
(
    input  logic [LC_CNT_W-1:0] n,
    output logic [SCORE_W-1:0]  points
);

    assign points = line_score(n);

endmodule

// File: rtl/line_clear.sv
// Row-elimination stage. On start, snapshots the playfield, drops every full row and
// compacts the survivors toward the bottom, shifting empty rows in at the top.
// Optional feature macro: LINE_CLEAR_SCORE_EN (adds a saturating running score).
// clk  : system clock
// rst  : synchronous, active-high reset
// bus  : line_clear_if.slave (start/grid_i in; busy/done/grid_o/lines_cleared[/score] out)
module line_clear
    import tetris_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    line_clear_if.slave  bus
);

    lc_state_t           state;
    row_t                grid_q [ROWS];
    logic [LC_PTR_W-1:0] rd;
    logic [LC_PTR_W-1:0] wr;
    logic [LC_CNT_W-1:0] cnt;
    logic [LC_CNT_W-1:0] cnt_next;
    logic [LC_CNT_W-1:0] lines_q;
    logic                busy_q;
    logic                done_q;
    logic                row_full;
    logic [LC_IDX_W-1:0] rd_idx;
    logic [LC_IDX_W-1:0] wr_idx;

    // Only used to index while the pointers are in range; the extra MSB guards the last step.
    assign rd_idx = rd[LC_IDX_W-1:0];
    assign wr_idx = wr[LC_IDX_W-1:0];

    always_comb begin
        row_full = &grid_q[rd_idx];
        cnt_next = row_full ? cnt + LC_CNT_W'(1) : cnt;
    end

    // Compaction happens in place: wr never drops below rd, so a copy never clobbers an
    // unread row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LC_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= '0;
            rd      <= '0;
            wr      <= '0;
            cnt     <= '0;
            for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                LC_IDLE: begin
                    if (bus.start) begin
                        for (int r = 0; r < ROWS; r++) grid_q[r] <= bus.grid_i[r];
                        rd     <= LC_PTR_W'(ROWS - 1);
                        wr     <= LC_PTR_W'(ROWS - 1);
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= LC_SCAN;
                    end
                end
                LC_SCAN: begin
                    if (!row_full) begin
                        grid_q[wr_idx] <= grid_q[rd_idx];
                        wr             <= wr - LC_PTR_W'(1);
                    end
                    rd  <= rd - LC_PTR_W'(1);
                    cnt <= cnt_next;
                    if (rd == '0) begin
                        if (cnt_next != '0) begin
                            state <= LC_FILL;
                        end else begin
                            state   <= LC_DONE;
                            done_q  <= 1'b1;
                            lines_q <= '0;
                        end
                    end
                end
                LC_FILL: begin
                    // wr starts at cnt-1 here, so reaching row 0 means cnt rows were zeroed.
                    grid_q[wr_idx] <= '0;
                    wr             <= wr - LC_PTR_W'(1);
                    if (wr == '0) begin
                        state   <= LC_DONE;
                        done_q  <= 1'b1;
                        lines_q <= cnt;
                    end
                end
                LC_DONE: begin
                    busy_q <= 1'b0;
                    state  <= LC_IDLE;
                end
                default: state <= LC_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.grid_o        = grid_q;
    assign bus.lines_cleared = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W-1:0] points;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_q;

    line_score_lut u_score_lut (
        .n      (lines_q),
        .points (points)
    );

    always_comb begin
        score_sum = {1'b0, score_q} + {1'b0, points};
    end

    // lines_q already holds this operation's count while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else if (state == LC_DONE) begin
            score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
    end

    assign bus.score = score_q;
`endif

endmodule
